// File: rtl/ex_mem_pkg.sv
// Shared types and defaults for the EX/MEM pipeline stage register.
// Compile before ex_mem_sat_cnt.sv and ex_mem_stage_reg.sv.
package ex_mem_pkg;

   localparam int EX_MEM_DATA_W = 32;
   localparam int EX_MEM_REG_AW = 5;

   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_to_reg;
      logic mem_write;
      logic reg_write;
      logic zero;
   } ex_mem_ctrl_t;

   localparam ex_mem_ctrl_t EX_MEM_CTRL_BUBBLE = '0;

   // Side-effecting controls must never survive in a slot that holds no instruction.
   function automatic ex_mem_ctrl_t ex_mem_gate_ctrl(input ex_mem_ctrl_t c, input logic v);
      ex_mem_ctrl_t g;
      g           = c;
      g.branch    = c.branch    & v;
      g.mem_read  = c.mem_read  & v;
      g.mem_write = c.mem_write & v;
      g.reg_write = c.reg_write & v;
      return g;
   endfunction

endpackage

// File: rtl/ex_mem_sat_cnt.sv
// Saturating event counter with enable and asynchronous active-high reset.
module ex_mem_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_max;

   assign w_at_max = &r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_en && !w_at_max) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with valid bit, stall hold and flush-to-bubble.
// Optional stall/flush performance counters are built when EX_MEM_PERF_EN is defined.
module ex_mem_stage_reg
   import ex_mem_pkg::*;
#(
   parameter int DATA_W = EX_MEM_DATA_W,
   parameter int REG_AW = EX_MEM_REG_AW
`ifdef EX_MEM_PERF_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_in,
   input  logic              branch_in,
   input  logic              mem_read_in,
   input  logic              mem_to_reg_in,
   input  logic              mem_write_in,
   input  logic              reg_write_in,
   input  logic              zero_in,
   input  logic [DATA_W-1:0] alu_target_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] read_data2_in,
   input  logic [REG_AW-1:0] dest_in,
   output logic              valid_out,
   output logic              branch_out,
   output logic              mem_read_out,
   output logic              mem_to_reg_out,
   output logic              mem_write_out,
   output logic              reg_write_out,
   output logic              zero_out,
   output logic [DATA_W-1:0] alu_target_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] read_data2_out,
   output logic [REG_AW-1:0] dest_out,
   output logic              pc_src_out
`ifdef EX_MEM_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   logic              r_valid;
   ex_mem_ctrl_t      r_ctrl;
   logic [DATA_W-1:0] r_alu_target;
   logic [DATA_W-1:0] r_alu_result;
   logic [DATA_W-1:0] r_read_data2;
   logic [REG_AW-1:0] r_dest;

   ex_mem_ctrl_t      w_ctrl_raw;
   ex_mem_ctrl_t      w_ctrl_in;
   logic              w_load;

   always_comb begin
      w_ctrl_raw            = EX_MEM_CTRL_BUBBLE;
      w_ctrl_raw.branch     = branch_in;
      w_ctrl_raw.mem_read   = mem_read_in;
      w_ctrl_raw.mem_to_reg = mem_to_reg_in;
      w_ctrl_raw.mem_write  = mem_write_in;
      w_ctrl_raw.reg_write  = reg_write_in;
      w_ctrl_raw.zero       = zero_in;
   end

   assign w_ctrl_in = ex_mem_gate_ctrl(w_ctrl_raw, valid_in);
   assign w_load    = !flush && !stall;

   // Flush turns the slot into a bubble but leaves the data fields untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_ctrl  <= EX_MEM_CTRL_BUBBLE;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_ctrl  <= EX_MEM_CTRL_BUBBLE;
      end else if (!stall) begin
         r_valid <= valid_in;
         r_ctrl  <= w_ctrl_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alu_target <= '0;
         r_alu_result <= '0;
         r_read_data2 <= '0;
         r_dest       <= '0;
      end else if (w_load) begin
         r_alu_target <= alu_target_in;
         r_alu_result <= alu_result_in;
         r_read_data2 <= read_data2_in;
         r_dest       <= dest_in;
      end
   end

   assign valid_out      = r_valid;
   assign branch_out     = r_ctrl.branch;
   assign mem_read_out   = r_ctrl.mem_read;
   assign mem_to_reg_out = r_ctrl.mem_to_reg;
   assign mem_write_out  = r_ctrl.mem_write;
   assign reg_write_out  = r_ctrl.reg_write;
   assign zero_out       = r_ctrl.zero;
   assign alu_target_out = r_alu_target;
   assign alu_result_out = r_alu_result;
   assign read_data2_out = r_read_data2;
   assign dest_out       = r_dest;
   assign pc_src_out     = r_ctrl.branch & r_ctrl.zero & r_valid;

`ifdef EX_MEM_PERF_EN
   logic w_stall_inc;
   logic w_flush_inc;

   // Only stalls that hold a real instruction are counted.
   assign w_stall_inc = stall & ~flush & r_valid;
   assign w_flush_inc = flush;

   ex_mem_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_stall_inc),
      .o_cnt (stall_cnt)
   );

   ex_mem_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_flush_inc),
      .o_cnt (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed plan steps, then random traffic
// compared every cycle against a slot-level reference model.
module tb_ex_mem_stage_reg;

   localparam int DW = 32;
   localparam int AW = 5;
`ifdef EX_MEM_PERF_EN
   localparam int CW = 4;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
   logic          branch_in = 1'b0, mem_read_in = 1'b0, mem_to_reg_in = 1'b0;
   logic          mem_write_in = 1'b0, reg_write_in = 1'b0, zero_in = 1'b0;
   logic [DW-1:0] alu_target_in = '0, alu_result_in = '0, read_data2_in = '0;
   logic [AW-1:0] dest_in = '0;
   logic          valid_out, branch_out, mem_read_out, mem_to_reg_out;
   logic          mem_write_out, reg_write_out, zero_out, pc_src_out;
   logic [DW-1:0] alu_target_out, alu_result_out, read_data2_out;
   logic [AW-1:0] dest_out;
`ifdef EX_MEM_PERF_EN
   logic [CW-1:0] stall_cnt, flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_mem_stage_reg #(
      .DATA_W(DW),
      .REG_AW(AW)
`ifdef EX_MEM_PERF_EN
      ,
      .CNT_W(CW)
`endif
   ) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
      .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
      .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .zero_in(zero_in),
      .alu_target_in(alu_target_in), .alu_result_in(alu_result_in),
      .read_data2_in(read_data2_in), .dest_in(dest_in),
      .valid_out(valid_out), .branch_out(branch_out), .mem_read_out(mem_read_out),
      .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
      .reg_write_out(reg_write_out), .zero_out(zero_out),
      .alu_target_out(alu_target_out), .alu_result_out(alu_result_out),
      .read_data2_out(read_data2_out), .dest_out(dest_out), .pc_src_out(pc_src_out)
`ifdef EX_MEM_PERF_EN
      ,
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // Reference model: the instruction slot currently sitting in MEM.
   typedef struct {
      bit          valid, branch, mem_read, mem_to_reg, mem_write, reg_write, zero;
      bit [DW-1:0] tgt, res, rd2;
      bit [AW-1:0] dest;
   } slot_t;

   slot_t       m;
   int unsigned m_scnt, m_fcnt;
   int unsigned cnt_max;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m      = '{default: 0};
         m_scnt = 0;
         m_fcnt = 0;
      end else begin
         if (stall && !flush && m.valid && m_scnt < cnt_max) m_scnt++;
         if (flush && m_fcnt < cnt_max) m_fcnt++;
         if (flush) begin
            // bubble: nothing executes, data left as it was
            m.valid = 0; m.branch = 0; m.mem_read = 0; m.mem_to_reg = 0;
            m.mem_write = 0; m.reg_write = 0; m.zero = 0;
         end else if (!stall) begin
            m.valid      = valid_in;
            m.branch     = valid_in && branch_in;
            m.mem_read   = valid_in && mem_read_in;
            m.mem_write  = valid_in && mem_write_in;
            m.reg_write  = valid_in && reg_write_in;
            m.mem_to_reg = mem_to_reg_in;
            m.zero       = zero_in;
            m.tgt        = alu_target_in;
            m.res        = alu_result_in;
            m.rd2        = read_data2_in;
            m.dest       = dest_in;
         end
      end
   end

   always @(negedge clk) begin
      chk("valid",      64'(valid_out),      64'(m.valid));
      chk("branch",     64'(branch_out),     64'(m.branch));
      chk("mem_read",   64'(mem_read_out),   64'(m.mem_read));
      chk("mem_to_reg", 64'(mem_to_reg_out), 64'(m.mem_to_reg));
      chk("mem_write",  64'(mem_write_out),  64'(m.mem_write));
      chk("reg_write",  64'(reg_write_out),  64'(m.reg_write));
      chk("zero",       64'(zero_out),       64'(m.zero));
      chk("alu_target", 64'(alu_target_out), 64'(m.tgt));
      chk("alu_result", 64'(alu_result_out), 64'(m.res));
      chk("read_data2", 64'(read_data2_out), 64'(m.rd2));
      chk("dest",       64'(dest_out),       64'(m.dest));
      chk("pc_src",     64'(pc_src_out),     64'(m.valid && m.branch && m.zero));
`ifdef EX_MEM_PERF_EN
      chk("stall_cnt",  64'(stall_cnt),      64'(m_scnt));
      chk("flush_cnt",  64'(flush_cnt),      64'(m_fcnt));
`endif
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      stall = 0; flush = 0; valid_in = 0; branch_in = 0; mem_read_in = 0;
      mem_to_reg_in = 0; mem_write_in = 0; reg_write_in = 0; zero_in = 0;
      alu_target_in = '0; alu_result_in = '0; read_data2_in = '0; dest_in = '0;
   endtask

   initial begin
`ifdef EX_MEM_PERF_EN
      cnt_max = (1 << CW) - 1;
`else
      cnt_max = 32'hFFFF;
`endif
      clear_inputs();
      reset = 1;
      step(); step();
      chk("reset_valid", 64'(valid_out), 64'd0);
      chk("reset_pc_src", 64'(pc_src_out), 64'd0);
      reset = 0;
      $display("reset released");

      // 1: async reset mid-cycle clears outputs before the next edge
      valid_in = 1; reg_write_in = 1; branch_in = 1; zero_in = 1;
      alu_result_in = 32'h5555_AAAA; dest_in = 5'd3;
      step();
      chk("pre_reset_valid", 64'(valid_out), 64'd1);
      #2 reset = 1;
      #1;
      chk("async_valid", 64'(valid_out), 64'd0);
      chk("async_res", 64'(alu_result_out), 64'd0);
      chk("async_regw", 64'(reg_write_out), 64'd0);
      chk("async_pc_src", 64'(pc_src_out), 64'd0);
      step();
      reset = 0;
      clear_inputs();
      valid_in = 1; alu_result_in = 32'h0000_1234; dest_in = 5'd9;
      step();
      chk("t1_res", 64'(alu_result_out), 64'h1234);
      chk("t1_dest", 64'(dest_out), 64'd9);
      $display("txn: reset-then-load res=%h dest=%0d", alu_result_out, dest_out);

      // 2: normal load
      clear_inputs();
      valid_in = 1; reg_write_in = 1; alu_result_in = 32'hDEAD_BEEF;
      step();
      chk("t2_regw", 64'(reg_write_out), 64'd1);
      chk("t2_res", 64'(alu_result_out), 64'hDEAD_BEEF);
      chk("t2_valid", 64'(valid_out), 64'd1);
      chk("model_t2_res", 64'(m.res), 64'hDEAD_BEEF);
      $display("txn: load res=%h", alu_result_out);

      // 3: stall holds for three cycles
      stall = 1; alu_result_in = 32'h1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_hold_res", 64'(alu_result_out), 64'hDEAD_BEEF);
         chk("t3_hold_valid", 64'(valid_out), 64'd1);
      end
      stall = 0;
      step();
      chk("t3_release_res", 64'(alu_result_out), 64'h1);
      $display("txn: stall release res=%h", alu_result_out);

      // 4: flush wins over stall, data kept
      clear_inputs();
      valid_in = 1; mem_write_in = 1; alu_result_in = 32'hCAFE_0000;
      step();
      chk("t4_memw", 64'(mem_write_out), 64'd1);
      stall = 1; flush = 1; alu_result_in = 32'h0BAD_0BAD;
      step();
      chk("t4_valid", 64'(valid_out), 64'd0);
      chk("t4_memw_flushed", 64'(mem_write_out), 64'd0);
      chk("t4_res_kept", 64'(alu_result_out), 64'hCAFE_0000);
      chk("model_t4_valid", 64'(m.valid), 64'd0);
      $display("txn: stall+flush res=%h valid=%0d", alu_result_out, valid_out);

      // 5: branch taken, then the same branch in a non-valid slot
      clear_inputs();
      valid_in = 1; branch_in = 1; zero_in = 1; alu_target_in = 32'h0000_0040;
      step();
      chk("t5_pc_src", 64'(pc_src_out), 64'd1);
      chk("t5_target", 64'(alu_target_out), 64'h40);
      valid_in = 0;
      step();
      chk("t5_pc_src_inv", 64'(pc_src_out), 64'd0);
      chk("t5_branch_gated", 64'(branch_out), 64'd0);
      chk("t5_zero_kept", 64'(zero_out), 64'd1);
      chk("t5_target_inv", 64'(alu_target_out), 64'h40);
      $display("txn: branch pc_src=%0d", pc_src_out);

`ifdef EX_MEM_PERF_EN
      // 6: counters saturate at 15 and count flushes
      clear_inputs();
      reset = 1;
      step();
      reset = 0;
      valid_in = 1;
      step();
      stall = 1;
      for (int i = 0; i < 20; i++) step();
      chk("t6_stall_sat", 64'(stall_cnt), 64'd15);
      stall = 0; flush = 1;
      step(); step();
      chk("t6_flush_cnt", 64'(flush_cnt), 64'd2);
      chk("model_t6_stall", 64'(m_scnt), 64'd15);
      flush = 0;
      $display("txn: perf stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
`endif

      // random traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         reset         = ($urandom_range(0, 199) == 0);
         stall         = ($urandom_range(0, 3) == 0);
         flush         = ($urandom_range(0, 9) == 0);
         valid_in      = ($urandom_range(0, 3) != 0);
         branch_in     = 1'($urandom);
         mem_read_in   = 1'($urandom);
         mem_to_reg_in = 1'($urandom);
         mem_write_in  = 1'($urandom);
         reg_write_in  = 1'($urandom);
         zero_in       = 1'($urandom);
         alu_target_in = $urandom;
         alu_result_in = $urandom;
         read_data2_in = $urandom;
         dest_in       = AW'($urandom);
         step();
      end
      reset = 0;
      clear_inputs();
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
